video_gen_sched: RTL and testbench
==================================

Name: video_gen_sched

Overview:
Frame scheduler and configuration controller for the video_gen timing generator feeding the MIPI TX path.
- Holds shadow timing registers, written over a simple config port.
- Commits them to video_gen only at frame boundaries.
- Enables and disables generation, inserts programmable inter-frame gaps and counts frames.
- Supports single-shot bursts of N frames or continuous streaming.

Parameters:
CNT_W, 16, width of timing values, gap counter and frame counters
DEF_H_ACTIVE, 1920, reset value of h_active shadow/active register
DEF_H_TOTAL, 2200, reset value of h_total
DEF_V_ACTIVE, 1080, reset value of v_active
DEF_V_TOTAL, 1125, reset value of v_total
TIMEOUT_W, 24, watchdog counter width (used only with the optional feature)

Ports:
clk  in  1  single system clock
rst  in  1  asynchronous, active-low reset
cfg_wr_valid  in  1  config write request
cfg_wr_ready  out  1  config write accept
cfg_addr  in  3  register address: 0 h_active, 1 h_total, 2 v_active, 3 v_total, 4 frame_gap, 5 frame_cnt; 6 and 7 are ignored
cfg_data  in  CNT_W  write data
start  in  1  pulse: begin a burst
stop  in  1  pulse: graceful stop
gen_valid_frame  in  1  valid_frame from video_gen
gen_en  out  1  enable/hold-off for video_gen
h_active_o, h_total_o, v_active_o, v_total_o  out  CNT_W each  committed timing to video_gen
frame_done  out  1  one-cycle pulse per completed frame
busy  out  1  high in any state other than IDLE
frames_sent  out  CNT_W  frames completed since last accepted start
cfg_err  out  1  sticky: invalid timing at commit
timeout_o  out  1  sticky watchdog flag (0 when feature is compiled out)

Behaviour:
- Reset values:
  - gen_en=0, busy=0, frame_done=0, frames_sent=0, cfg_err=0, timeout_o=0, cfg_wr_ready=1.
  - Shadow and active timing registers = DEF_* values; frame_gap=0, frame_cnt=0.
  - State = IDLE.
- Config writes:
  - Handshake completes when valid and ready are both high.
  - cfg_wr_ready=0 only in the LOAD cycle; at all other times writes update the shadow register in 1 cycle.
  - Active outputs change only in LOAD.
- Frame end: falling edge of registered gen_valid_frame. The edge detector adds 1 cycle of latency.
- States:
  - IDLE: gen_en=0. On start with stop low: clear frames_sent and cfg_err, go to LOAD. Start and stop in the same cycle: stop wins, stay IDLE.
  - LOAD (1 cycle): copy shadow to active outputs, then validate.
    - Valid requires h_active!=0, v_active!=0, h_active<h_total and v_active<v_total.
    - Invalid: set cfg_err, go to IDLE.
    - Valid: go to RUN, gen_en=1 from the next cycle.
  - RUN: gen_en=1. At each frame end: frame_done pulse, frames_sent+1 (saturating at all-ones). Then:
    - stop_pending, or frame_cnt!=0 and frames_sent+1==frame_cnt: go to IDLE, gen_en=0, clear stop_pending.
    - Else frame_gap==0: go to LOAD (back-to-back frames with new shadow values).
    - Else: go to GAP, load gap counter with frame_gap, gen_en=0.
  - GAP: counter decrements each cycle; at value 1 go to LOAD. So frame_gap=G gives exactly G cycles with gen_en=0 before LOAD.
- stop handling:
  - In IDLE: ignored.
  - In LOAD or RUN: sets stop_pending; the current frame completes.
  - In GAP: go to IDLE next cycle.
- start while busy is ignored.
- frame_cnt=0 means continuous streaming.
- Reset asserted mid-frame returns everything to reset values immediately; gen_en drops asynchronously.

Optional Feature:
FRAME_TIMEOUT_EN
- With the macro: a watchdog counter of TIMEOUT_W bits runs in RUN and clears at each frame end and on entry to RUN. On reaching all-ones: gen_en=0, state goes to IDLE, timeout_o=1 (sticky, cleared by the next accepted start).
- Without the macro: no counter is built and timeout_o is tied 0.

Decomposition:
- Package video_sched_pkg holds:
  - state enum (IDLE, LOAD, RUN, GAP);
  - config address constants;
  - DEF_* timing constants shared with video_gen.
- One natural sub-module: vgen_frame_end_det, which registers gen_valid_frame and emits the one-cycle frame-end pulse.

Test Plan:
- Reset, then write frame_cnt=3, frame_gap=10, start. Expect 3 frame_done pulses and frames_sent=3. Exactly 10 cycles of gen_en=0 between frames. busy falls after the third frame.
- During RUN, write h_active=1280 and h_total=1650. Expect h_active_o to stay 1920 until the next LOAD, then read 1280. cfg_wr_ready=0 only in the LOAD cycle.
- Write h_active=2200 and h_total=2200, then start. Expect cfg_err=1, gen_en never asserted, busy back to 0 after 1 cycle.
- frame_cnt=0, frame_gap=0, start, stop mid-frame. Expect the current frame to complete with frame_done, gen_en=0 the next cycle, and frames_sent equal to the frames completed.
- Start and stop in the same IDLE cycle. Expect busy to stay 0. Stop during GAP gives IDLE in 1 cycle.
- With FRAME_TIMEOUT_EN and TIMEOUT_W=8: hold gen_valid_frame=1 after start. Expect timeout_o=1 and gen_en=0 within 256 cycles of entering RUN. The next start clears timeout_o.

Source files
------------

// File: rtl/video_sched_pkg.sv
// Shared types and constants for the video_gen frame scheduler.
// State encoding, config register map and default 1080p timing.
package video_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    GAP
  } state_e;

  localparam logic [2:0] A_H_ACTIVE  = 3'd0;
  localparam logic [2:0] A_H_TOTAL   = 3'd1;
  localparam logic [2:0] A_V_ACTIVE  = 3'd2;
  localparam logic [2:0] A_V_TOTAL   = 3'd3;
  localparam logic [2:0] A_FRAME_GAP = 3'd4;
  localparam logic [2:0] A_FRAME_CNT = 3'd5;

  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_TOTAL  = 2200;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_TOTAL  = 1125;

endpackage

// File: rtl/vgen_frame_end_det.sv
// Registers valid_frame from video_gen and emits a one-cycle
// frame-end pulse on its falling edge.
module vgen_frame_end_det (
  input  logic clk,
  input  logic rst,
  input  logic valid_frame_i,
  output logic frame_end_o
);

  logic vf_q;
  logic fe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vf_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      vf_q <= valid_frame_i;
      fe_q <= vf_q & ~valid_frame_i;
    end
  end

  assign frame_end_o = fe_q;

endmodule

// File: rtl/video_gen_sched.sv
// Frame scheduler / config controller for video_gen.
// Optional watchdog: define FRAME_TIMEOUT_EN.
module video_gen_sched
  import video_sched_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEF_H_ACT    = DEF_H_ACTIVE,
  parameter int DEF_H_TOT    = DEF_H_TOTAL,
  parameter int DEF_V_ACT    = DEF_V_ACTIVE,
  parameter int DEF_V_TOT    = DEF_V_TOTAL,
  parameter int TIMEOUT_W    = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_valid,
  output logic             cfg_wr_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             gen_valid_frame,
  output logic             gen_en,
  output logic [CNT_W-1:0] h_active_o,
  output logic [CNT_W-1:0] h_total_o,
  output logic [CNT_W-1:0] v_active_o,
  output logic [CNT_W-1:0] v_total_o,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent,
  output logic             cfg_err,
  output logic             timeout_o
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] sh_ha_q, sh_ht_q, sh_va_q, sh_vt_q;
  logic [CNT_W-1:0] ha_q, ht_q, va_q, vt_q;
  logic [CNT_W-1:0] gap_q, fcnt_q;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [CNT_W-1:0] fs_q, fs_d, fs_inc;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic             fe, wr, cfg_ok, fs_last, wd_hit;

  vgen_frame_end_det u_fe (
    .clk           (clk),
    .rst           (rst),
    .valid_frame_i (gen_valid_frame),
    .frame_end_o   (fe)
  );

  assign cfg_wr_ready = (state_q != LOAD);
  assign wr           = cfg_wr_valid & cfg_wr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_ha_q <= CNT_W'(DEF_H_ACT);
      sh_ht_q <= CNT_W'(DEF_H_TOT);
      sh_va_q <= CNT_W'(DEF_V_ACT);
      sh_vt_q <= CNT_W'(DEF_V_TOT);
      gap_q   <= '0;
      fcnt_q  <= '0;
    end else if (wr) begin
      case (cfg_addr)
        A_H_ACTIVE:  sh_ha_q <= cfg_data;
        A_H_TOTAL:   sh_ht_q <= cfg_data;
        A_V_ACTIVE:  sh_va_q <= cfg_data;
        A_V_TOTAL:   sh_vt_q <= cfg_data;
        A_FRAME_GAP: gap_q   <= cfg_data;
        A_FRAME_CNT: fcnt_q  <= cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ha_q <= CNT_W'(DEF_H_ACT);
      ht_q <= CNT_W'(DEF_H_TOT);
      va_q <= CNT_W'(DEF_V_ACT);
      vt_q <= CNT_W'(DEF_V_TOT);
    end else if (state_q == LOAD) begin
      ha_q <= sh_ha_q;
      ht_q <= sh_ht_q;
      va_q <= sh_va_q;
      vt_q <= sh_vt_q;
    end
  end

  assign cfg_ok = (sh_ha_q != '0) && (sh_va_q != '0) &&
                  (sh_ha_q < sh_ht_q) && (sh_va_q < sh_vt_q);

  assign fs_inc  = (&fs_q) ? fs_q : fs_q + 1'b1;
  assign fs_last = (fcnt_q != '0) && (fs_inc == fcnt_q);

`ifdef FRAME_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q;

  // Restarts on every frame end and whenever RUN is (re)entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (state_q != RUN || fe) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_hit = (state_q == RUN) && (&wd_q);
`else
  logic unused_tw;
  assign unused_tw = |TIMEOUT_W;
  assign wd_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    fs_d    = fs_q;
    pend_d  = pend_q;
    err_d   = err_q;
    to_d    = to_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          fs_d    = '0;
          err_d   = 1'b0;
          to_d    = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (stop) pend_d = 1'b1;
        if (!cfg_ok) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) pend_d = 1'b1;
        if (fe) begin
          done_d = 1'b1;
          fs_d   = fs_inc;
          if (pend_q || stop || fs_last) begin
            state_d = IDLE;
          end else if (gap_q == '0) begin
            state_d = LOAD;
          end else begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (gcnt_q == CNT_W'(1)) begin
          state_d = LOAD;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      fs_q    <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      fs_q    <= fs_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign gen_en      = (state_q == RUN);
  assign busy        = (state_q != IDLE);
  assign h_active_o  = ha_q;
  assign h_total_o   = ht_q;
  assign v_active_o  = va_q;
  assign v_total_o   = vt_q;
  assign frame_done  = done_q;
  assign frames_sent = fs_q;
  assign cfg_err     = err_q;
  assign timeout_o   = to_q;

endmodule

// File: tb/tb_video_gen_sched.sv
// Self-checking bench for video_gen_sched (scoreboard of
// expected frames_sent values popped on each frame_done).
module tb_video_gen_sched;

  localparam int W = 16;
`ifdef FRAME_TIMEOUT_EN
  localparam int TW = 8;
`else
  localparam int TW = 24;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_wr_valid = 1'b0;
  logic         cfg_wr_ready;
  logic [2:0]   cfg_addr = '0;
  logic [W-1:0] cfg_data = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         gvf = 1'b0;
  logic         gen_en;
  logic [W-1:0] h_active_o, h_total_o, v_active_o, v_total_o;
  logic         frame_done;
  logic         busy;
  logic [W-1:0] frames_sent;
  logic         cfg_err;
  logic         timeout_o;

  always #5 clk = ~clk;

  video_gen_sched #(.CNT_W(W), .TIMEOUT_W(TW)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_valid    (cfg_wr_valid),
    .cfg_wr_ready    (cfg_wr_ready),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .start           (start),
    .stop            (stop),
    .gen_valid_frame (gvf),
    .gen_en          (gen_en),
    .h_active_o      (h_active_o),
    .h_total_o       (h_total_o),
    .v_active_o      (v_active_o),
    .v_total_o       (v_total_o),
    .frame_done      (frame_done),
    .busy            (busy),
    .frames_sent     (frames_sent),
    .cfg_err         (cfg_err),
    .timeout_o       (timeout_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [W-1:0] exp_q[$];
  int           exp_fs = 0;
  int           done_seen = 0;
  int           gap_cyc = 0;
  int           load_cyc = 0;
  logic         gen_at_done = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      if (frame_done) begin
        done_seen++;
        gen_at_done = gen_en;
        if (exp_q.size() == 0) chk("fd_unexp", 1, 0);
        else chk("fs_at_done", frames_sent, exp_q.pop_front());
      end
      if (busy && !gen_en && cfg_wr_ready) gap_cyc++;
      if (!cfg_wr_ready) load_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cfg(input logic [2:0] a, input int d);
    int n = 0;
    cfg_wr_valid = 1'b1;
    cfg_addr     = a;
    cfg_data     = W'(d);
    while (!cfg_wr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("wr_ready_wait", 0, 1);
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_gen();
    int n = 0;
    while (!gen_en && n < 200) begin
      tick();
      n++;
    end
    chk("gen_wait", gen_en, 1);
  endtask

  task automatic run_frame(input int len, input int stop_at);
    wait_gen();
    gvf = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    gvf = 1'b0;
    exp_fs++;
    exp_q.push_back(W'(exp_fs));
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_gen_en", gen_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_fs", frames_sent, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_ready", cfg_wr_ready, 1);
    chk("rst_ha", h_active_o, 1920);
    chk("rst_ht", h_total_o, 2200);
    chk("rst_va", v_active_o, 1080);
    chk("rst_vt", v_total_o, 1125);
    rst = 1'b1;
    tick();

    // burst of 3 frames with 10-cycle gaps
    wr_cfg(3'd5, 3);
    wr_cfg(3'd4, 10);
    gap_cyc = 0; load_cyc = 0; done_seen = 0; exp_fs = 0;
    pulse_start();
    chk("b_busy", busy, 1);
    for (int f = 0; f < 3; f++) run_frame(20, -1);
    chk("b_fs", frames_sent, 3);
    chk("b_busy_end", busy, 0);
    chk("b_gen_end", gen_en, 0);
    chk("b_gap_cyc", gap_cyc, 20);
    chk("b_load_cyc", load_cyc, 3);
    chk("b_dones", done_seen, 3);

    // shadow update while running commits at next LOAD
    wr_cfg(3'd5, 2);
    wr_cfg(3'd4, 0);
    exp_fs = 0;
    pulse_start();
    wait_gen();
    wr_cfg(3'd0, 1280);
    wr_cfg(3'd1, 1650);
    chk("sh_ha_hold", h_active_o, 1920);
    chk("sh_ht_hold", h_total_o, 2200);
    run_frame(20, -1);
    wait_gen();
    chk("sh_ha_new", h_active_o, 1280);
    chk("sh_ht_new", h_total_o, 1650);
    run_frame(20, -1);
    chk("sh_busy", busy, 0);
    chk("sh_fs", frames_sent, 2);

    // invalid timing: h_active == h_total
    wr_cfg(3'd0, 2200);
    wr_cfg(3'd1, 2200);
    pulse_start();
    chk("inv_busy_load", busy, 1);
    chk("inv_gen_load", gen_en, 0);
    tick();
    chk("inv_busy", busy, 0);
    chk("inv_err", cfg_err, 1);
    chk("inv_gen", gen_en, 0);
    chk("inv_ha", h_active_o, 2200);
    chk("inv_fs", frames_sent, 0);
    wr_cfg(3'd0, 1280);

    // continuous, stop mid third frame
    wr_cfg(3'd5, 0);
    exp_fs = 0;
    pulse_start();
    tick();
    chk("cs_err_clr", cfg_err, 0);
    run_frame(15, -1);
    run_frame(15, -1);
    run_frame(15, 5);
    chk("cs_gen_at_done", gen_at_done, 0);
    chk("cs_busy", busy, 0);
    chk("cs_fs", frames_sent, 3);

    // start+stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy0", busy, 0);
    tick();
    chk("ss_busy1", busy, 0);

    // stop during GAP
    wr_cfg(3'd4, 20);
    exp_fs = 0;
    pulse_start();
    run_frame(10, -1);
    chk("gs_busy", busy, 1);
    chk("gs_gen", gen_en, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("gs_idle", busy, 0);
    wr_cfg(3'd4, 0);

`ifdef FRAME_TIMEOUT_EN
    begin
      int n = 0;
      pulse_start();
      wait_gen();
      gvf = 1'b1;
      while (!timeout_o && n < 300) begin
        tick();
        n++;
      end
      chk("to_set", timeout_o, 1);
      chk("to_gen", gen_en, 0);
      chk("to_lat", (n <= 256), 1);
      gvf = 1'b0;
      repeat (3) tick();
      exp_fs = 0;
      pulse_start();
      chk("to_clr", timeout_o, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      run_frame(5, -1);
      chk("to_fs", frames_sent, 1);
    end
`else
    chk("to_off", timeout_o, 0);
`endif

    // asynchronous reset mid-frame
    pulse_start();
    wait_gen();
    gvf = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("ar_gen", gen_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ha", h_active_o, 1920);
    chk("ar_fs", frames_sent, 0);
    gvf = 1'b0;
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("ar_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
